// File: rtl/rhythm_pkg.sv
// rtl/rhythm_pkg.sv - shared types and constants for the multi-lane rhythm judge
//
// Purpose: accuracy codes, FSM state encoding and hit-window bit offsets used by
//          rhythm_lane and rhythm_judge_multi.
// Ports:   none (package).

package rhythm_pkg;

   typedef enum logic [1:0] {
      ACC_NONE    = 2'b00,
      ACC_PERFECT = 2'b01,
      ACC_GOOD    = 2'b10,
      ACC_MISS    = 2'b11
   } acc_e;

   typedef enum logic [2:0] {
      IDLE,
      LOADED,
      RUN,
      PAUSE,
      DONE
   } state_e;

   // Positions inside the lane shifter that form the hit window.
   localparam int PERFECT_IDX = 1;
   localparam int GOOD_IDX0   = 0;
   localparam int GOOD_IDX2   = 2;

endpackage

// File: rtl/rhythm_lane.sv
// rtl/rhythm_lane.sv - one note lane: map shifter, press edge detect, window judgement
//
// Purpose: holds one lane of the note map, shifts it on tick while running,
//          grades a button press against the pre-shift window and flags notes
//          that fall out of bit0 unpressed.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   load            copy map_in into the shifter
//   run             FSM is in RUN (judging and shifting enabled)
//   tick            beat strobe
//   map_in          lane map, bit0 arrives first
//   btn_n           active-low lane button (already synchronised)
//   view            shifter bits [VIEW:1] for display
//   hit_perfect     press graded PERFECT this cycle
//   hit_good        press graded GOOD this cycle
//   judged          a press was judged this cycle (hit or stray)
//   miss            a note leaves bit0 unpressed this cycle
//   empty           shifter holds no notes

module rhythm_lane
   import rhythm_pkg::*;
#(
   parameter int MAP_LEN = 192,
   parameter int VIEW    = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               run,
   input  logic               tick,
   input  logic [MAP_LEN-1:0] map_in,
   input  logic               btn_n,
   output logic [VIEW-1:0]    view,
   output logic               hit_perfect,
   output logic               hit_good,
   output logic               judged,
   output logic               miss,
   output logic               empty
);

   logic [MAP_LEN-1:0] sh_q, sh_d;
   logic               btn_prev_q, btn_prev_d;
   logic [MAP_LEN-1:0] cleared;
   logic               press;

   always_comb begin
      press       = btn_prev_q & ~btn_n;
      judged      = run & press;
      cleared     = sh_q;
      hit_perfect = 1'b0;
      hit_good    = 1'b0;

      if (judged) begin
         if (sh_q[PERFECT_IDX]) begin
            hit_perfect          = 1'b1;
            cleared[PERFECT_IDX] = 1'b0;
         end else if (sh_q[GOOD_IDX0]) begin
            hit_good           = 1'b1;
            cleared[GOOD_IDX0] = 1'b0;
         end else if (sh_q[GOOD_IDX2]) begin
            hit_good           = 1'b1;
            cleared[GOOD_IDX2] = 1'b0;
         end
      end

      // Checked after the judgement so a note just hit in bit0 is not also a miss.
      miss = run & tick & cleared[0];

      sh_d = sh_q;
      if (load) begin
         sh_d = map_in;
      end else if (run && tick) begin
         sh_d = {1'b0, cleared[MAP_LEN-1:1]};
      end else if (judged) begin
         sh_d = cleared;
      end

      // History follows the button in every state so a press held across a
      // pause or load cannot produce a spurious edge later.
      btn_prev_d = btn_n;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sh_q       <= '0;
         btn_prev_q <= 1'b1;
      end else begin
         sh_q       <= sh_d;
         btn_prev_q <= btn_prev_d;
      end
   end

   assign view  = sh_q[VIEW:1];
   assign empty = ~|sh_q;

endmodule

// File: rtl/rhythm_judge_multi.sv
// rtl/rhythm_judge_multi.sv - multi-lane rhythm judge top: FSM, score/combo reduction
//
// Purpose: instantiates one rhythm_lane per lane, sequences IDLE/LOADED/RUN/
//          PAUSE/DONE and folds the per-lane judgements into saturating score,
//          combo and max combo plus the last-judgement report.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   tick            beat strobe (shift only in RUN)
//   load            copy map_bits into all lanes, clear counters, go LOADED
//   start           run/pause toggle
//   map_bits        lane i at [i*MAP_LEN +: MAP_LEN]
//   btn_n           active-low lane buttons
//   lane_view       per-lane shifter bits [VIEW:1]
//   score           saturating point total
//   combo           saturating current streak
//   max_combo       highest streak since load
//   accuracy        last judgement code
//   acc_lane        lane of last judgement
//   running, done   registered state flags

module rhythm_judge_multi
   import rhythm_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int MAP_LEN     = 192,
   parameter int VIEW        = 10,
   parameter int SCORE_W     = 8,
   parameter int COMBO_W     = 8,
   parameter int PTS_PERFECT = 2,
   parameter int PTS_GOOD    = 1,
   localparam int AL_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     load,
   input  logic                     start,
   input  logic [LANES*MAP_LEN-1:0] map_bits,
   input  logic [LANES-1:0]         btn_n,
   output logic [LANES*VIEW-1:0]    lane_view,
   output logic [SCORE_W-1:0]       score,
   output logic [COMBO_W-1:0]       combo,
   output logic [COMBO_W-1:0]       max_combo,
   output logic [1:0]               accuracy,
   output logic [AL_W-1:0]          acc_lane,
   output logic                     running,
   output logic                     done
);

   localparam int SUM_W = ((SCORE_W > COMBO_W) ? SCORE_W : COMBO_W) + 8;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

   logic [LANES-1:0] hit_perfect, hit_good, judged, miss, empty;
   logic             run;

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [COMBO_W-1:0] combo_q, combo_d;
   logic [COMBO_W-1:0] max_q, max_d;
   acc_e               acc_q, acc_d;
   logic [AL_W-1:0]    lane_q, lane_d;
   logic               running_q, running_d;
   logic               done_q, done_d;

   logic [SUM_W-1:0]   pts_sum, hit_cnt, score_ext, combo_ext;
   logic               any_miss, found_j;
   logic [AL_W-1:0]    miss_lane, j_lane;
   acc_e               j_acc;

   assign run = (state_q == RUN);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      rhythm_lane #(
         .MAP_LEN (MAP_LEN),
         .VIEW    (VIEW)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .load        (load),
         .run         (run),
         .tick        (tick),
         .map_in      (map_bits[g*MAP_LEN +: MAP_LEN]),
         .btn_n       (btn_n[g]),
         .view        (lane_view[g*VIEW +: VIEW]),
         .hit_perfect (hit_perfect[g]),
         .hit_good    (hit_good[g]),
         .judged      (judged[g]),
         .miss        (miss[g]),
         .empty       (empty[g])
      );
   end

   // Next state: load dominates everywhere, then start, then end-of-map.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = LOADED;
      end else begin
         case (state_q)
            LOADED:  if (start) state_d = RUN;
            RUN: begin
               if (start)       state_d = PAUSE;
               else if (&empty) state_d = DONE;
            end
            PAUSE:   if (start) state_d = RUN;
            default: state_d = state_q;
         endcase
      end
      running_d = (state_d == RUN);
      done_d    = (state_d == DONE);
   end

   // Fold lane results: sum points and hits, pick lowest judged / missed lane.
   always_comb begin
      pts_sum   = '0;
      hit_cnt   = '0;
      any_miss  = 1'b0;
      found_j   = 1'b0;
      miss_lane = '0;
      j_lane    = '0;
      j_acc     = ACC_NONE;
      for (int i = 0; i < LANES; i++) begin
         if (hit_perfect[i]) begin
            pts_sum = pts_sum + SUM_W'(PTS_PERFECT);
            hit_cnt = hit_cnt + 1'b1;
         end else if (hit_good[i]) begin
            pts_sum = pts_sum + SUM_W'(PTS_GOOD);
            hit_cnt = hit_cnt + 1'b1;
         end
         if (miss[i] && !any_miss) begin
            any_miss  = 1'b1;
            miss_lane = AL_W'(i);
         end
         if (judged[i] && !found_j) begin
            found_j = 1'b1;
            j_lane  = AL_W'(i);
            j_acc   = hit_perfect[i] ? ACC_PERFECT :
                      hit_good[i]    ? ACC_GOOD    : ACC_NONE;
         end
      end

      score_ext = SUM_W'(score_q) + pts_sum;
      combo_ext = SUM_W'(combo_q) + hit_cnt;

      if (load) begin
         score_d = '0;
         combo_d = '0;
         max_d   = '0;
         acc_d   = ACC_NONE;
         lane_d  = '0;
      end else begin
         score_d = (score_ext > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_ext[SCORE_W-1:0];
         // A miss anywhere breaks the streak even if other lanes hit.
         if (any_miss)
            combo_d = '0;
         else
            combo_d = (combo_ext > SUM_W'(COMBO_MAX)) ? COMBO_MAX : combo_ext[COMBO_W-1:0];
         max_d  = (combo_d > max_q) ? combo_d : max_q;
         acc_d  = acc_q;
         lane_d = lane_q;
         if (any_miss) begin
            acc_d  = ACC_MISS;
            lane_d = miss_lane;
         end else if (found_j) begin
            acc_d  = j_acc;
            lane_d = j_lane;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         score_q   <= '0;
         combo_q   <= '0;
         max_q     <= '0;
         acc_q     <= ACC_NONE;
         lane_q    <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         combo_q   <= combo_d;
         max_q     <= max_d;
         acc_q     <= acc_d;
         lane_q    <= lane_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign score     = score_q;
   assign combo     = combo_q;
   assign max_combo = max_q;
   assign accuracy  = acc_q;
   assign acc_lane  = lane_q;
   assign running   = running_q;
   assign done      = done_q;

endmodule

// File: tb/tb_rhythm_judge_multi.sv
// tb/tb_rhythm_judge_multi.sv - self-checking bench for rhythm_judge_multi

module tb_rhythm_judge_multi;

   localparam int LANES   = 4;
   localparam int MAP_LEN = 16;
   localparam int VIEW    = 10;
   localparam int SCORE_W = 4;
   localparam int COMBO_W = 8;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     tick, load, start;
   logic [LANES*MAP_LEN-1:0] map_bits;
   logic [LANES-1:0]         btn_n;
   logic [LANES*VIEW-1:0]    lane_view;
   logic [SCORE_W-1:0]       score;
   logic [COMBO_W-1:0]       combo, max_combo;
   logic [1:0]               accuracy;
   logic [1:0]               acc_lane;
   logic                     running, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rhythm_judge_multi #(
      .LANES   (LANES),
      .MAP_LEN (MAP_LEN),
      .VIEW    (VIEW),
      .SCORE_W (SCORE_W),
      .COMBO_W (COMBO_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .load      (load),
      .start     (start),
      .map_bits  (map_bits),
      .btn_n     (btn_n),
      .lane_view (lane_view),
      .score     (score),
      .combo     (combo),
      .max_combo (max_combo),
      .accuracy  (accuracy),
      .acc_lane  (acc_lane),
      .running   (running),
      .done      (done)
   );

   typedef struct {
      logic        load, start, tick;
      logic [3:0]  btn_n;
      logic [63:0] map;
      logic [3:0]  e_score;
      logic [7:0]  e_combo, e_max;
      logic [1:0]  e_acc, e_lane;
      logic        e_run, e_done;
      logic [39:0] e_view;
   } vec_t;

   vec_t vecs[$];

   localparam logic [63:0] M1 = 64'h0000_0000_0000_0002;
   localparam logic [63:0] M2 = 64'h0002_0001_0002_0002;
   localparam logic [63:0] M3 = 64'h0004_0000_0002_0000;
   localparam logic [63:0] M4 = 64'h0000_0000_0002_0010;
   localparam logic [63:0] M5 = 64'h0000_0000_0000_07FE;

   function automatic vec_t mk(input logic l, s, t, input logic [3:0] b, input logic [63:0] m,
                               input logic [3:0] sc, input logic [7:0] cb, mx,
                               input logic [1:0] ac, ln, input logic r, d, input logic [39:0] vw);
      vec_t x;
      x.load = l; x.start = s; x.tick = t; x.btn_n = b; x.map = m;
      x.e_score = sc; x.e_combo = cb; x.e_max = mx; x.e_acc = ac; x.e_lane = ln;
      x.e_run = r; x.e_done = d; x.e_view = vw;
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic l, s, t, input logic [3:0] b, input logic [63:0] m);
      load = l; start = s; tick = t; btn_n = b; map_bits = m;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; load = 0; start = 0; tick = 0; btn_n = 4'hF; map_bits = '0;

      //       ld st tk btn  map  score combo max acc lane run done view
      vecs.push_back(mk(0,1,0,4'hF,M1, 0,0,0,0,0,0,0,40'h0));          // start in IDLE ignored
      vecs.push_back(mk(1,0,0,4'hF,M1, 0,0,0,0,0,0,0,40'h1));
      vecs.push_back(mk(0,1,0,4'hF,M1, 0,0,0,0,0,1,0,40'h1));
      vecs.push_back(mk(0,0,0,4'hE,M1, 2,1,1,1,0,1,0,40'h0));          // PERFECT lane0
      vecs.push_back(mk(0,0,1,4'hF,M1, 2,1,1,1,0,0,1,40'h0));          // empty -> DONE, no miss
      vecs.push_back(mk(1,0,0,4'hF,M2, 0,0,0,0,0,0,0,40'h40000401));
      vecs.push_back(mk(0,1,0,4'hF,M2, 0,0,0,0,0,1,0,40'h40000401));
      vecs.push_back(mk(0,0,0,4'hE,M2, 2,1,1,1,0,1,0,40'h40000400));
      vecs.push_back(mk(0,0,0,4'hF,M2, 2,1,1,1,0,1,0,40'h40000400));
      vecs.push_back(mk(0,0,0,4'hD,M2, 4,2,2,1,1,1,0,40'h40000000));
      vecs.push_back(mk(0,0,0,4'hF,M2, 4,2,2,1,1,1,0,40'h40000000));
      vecs.push_back(mk(0,0,0,4'h7,M2, 6,3,3,1,3,1,0,40'h0));
      vecs.push_back(mk(0,0,1,4'hF,M2, 6,0,3,3,2,1,0,40'h0));          // MISS lane2
      vecs.push_back(mk(0,0,0,4'hF,M2, 6,0,3,3,2,0,1,40'h0));
      vecs.push_back(mk(1,0,0,4'hF,M3, 0,0,0,0,0,0,0,40'h80000400));
      vecs.push_back(mk(0,1,0,4'hF,M3, 0,0,0,0,0,1,0,40'h80000400));
      vecs.push_back(mk(0,0,1,4'h5,M3, 3,2,2,1,1,1,0,40'h0));          // simultaneous + tick
      vecs.push_back(mk(0,0,0,4'hF,M3, 3,2,2,1,1,0,1,40'h0));
      vecs.push_back(mk(1,0,0,4'hF,M4, 0,0,0,0,0,0,0,40'h408));
      vecs.push_back(mk(0,1,0,4'hF,M4, 0,0,0,0,0,1,0,40'h408));
      vecs.push_back(mk(0,0,0,4'hD,M4, 2,1,1,1,1,1,0,40'h8));
      vecs.push_back(mk(0,0,0,4'hF,M4, 2,1,1,1,1,1,0,40'h8));
      vecs.push_back(mk(0,0,0,4'hE,M4, 2,1,1,0,0,1,0,40'h8));          // stray lane0
      vecs.push_back(mk(0,0,1,4'hE,M4, 2,1,1,0,0,1,0,40'h4));          // held
      vecs.push_back(mk(0,0,1,4'hE,M4, 2,1,1,0,0,1,0,40'h2));
      vecs.push_back(mk(0,0,1,4'hE,M4, 2,1,1,0,0,1,0,40'h1));
      vecs.push_back(mk(0,1,0,4'hE,M4, 2,1,1,0,0,0,0,40'h1));          // pause
      vecs.push_back(mk(0,0,1,4'hE,M4, 2,1,1,0,0,0,0,40'h1));          // tick ignored in PAUSE
      vecs.push_back(mk(0,1,0,4'hE,M4, 2,1,1,0,0,1,0,40'h1));          // resume
      vecs.push_back(mk(0,0,1,4'hE,M4, 2,1,1,0,0,1,0,40'h0));          // note in bit0, held: no hit
      vecs.push_back(mk(0,0,1,4'hE,M4, 2,0,1,3,0,1,0,40'h0));          // MISS on exit
      vecs.push_back(mk(0,0,0,4'hF,M4, 2,0,1,3,0,0,1,40'h0));

      // Reset held two cycles
      @(posedge clk); @(posedge clk); #1;
      chk("rst score", 64'(score), 0);
      chk("rst combo", 64'(combo), 0);
      chk("rst max", 64'(max_combo), 0);
      chk("rst acc", 64'(accuracy), 0);
      chk("rst lane", 64'(acc_lane), 0);
      chk("rst run", 64'(running), 0);
      chk("rst done", 64'(done), 0);
      chk("rst view", 64'(lane_view), 0);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].load, vecs[i].start, vecs[i].tick, vecs[i].btn_n, vecs[i].map);
         chk($sformatf("row%0d score", i), 64'(score), 64'(vecs[i].e_score));
         chk($sformatf("row%0d combo", i), 64'(combo), 64'(vecs[i].e_combo));
         chk($sformatf("row%0d max", i), 64'(max_combo), 64'(vecs[i].e_max));
         chk($sformatf("row%0d acc", i), 64'(accuracy), 64'(vecs[i].e_acc));
         chk($sformatf("row%0d lane", i), 64'(acc_lane), 64'(vecs[i].e_lane));
         chk($sformatf("row%0d run", i), 64'(running), 64'(vecs[i].e_run));
         chk($sformatf("row%0d done", i), 64'(done), 64'(vecs[i].e_done));
         chk($sformatf("row%0d view", i), 64'(lane_view), 64'(vecs[i].e_view));
      end

      // Score saturation: ten PERFECT hits on lane0 with a 4-bit score
      step(1, 0, 0, 4'hF, M5);
      step(0, 1, 0, 4'hF, M5);
      for (int i = 1; i <= 10; i++) begin
         int exp_sc;
         exp_sc = (2 * i > 15) ? 15 : 2 * i;
         step(0, 0, 0, 4'hE, M5);
         chk($sformatf("sat%0d score", i), 64'(score), 64'(exp_sc));
         chk($sformatf("sat%0d combo", i), 64'(combo), 64'(i));
         chk($sformatf("sat%0d acc", i), 64'(accuracy), 64'(1));
         step(0, 0, 1, 4'hF, M5);
         chk($sformatf("sat%0d combo after tick", i), 64'(combo), 64'(i));
      end
      chk("sat done", 64'(done), 1);
      chk("sat run", 64'(running), 0);
      chk("sat max", 64'(max_combo), 10);
      chk("sat final score", 64'(score), 15);

      step(0, 1, 0, 4'hF, M5);                 // start ignored in DONE
      chk("done start ignored", 64'(done), 1);

      step(1, 0, 0, 4'hF, M5);
      chk("reload done", 64'(done), 0);
      chk("reload run", 64'(running), 0);
      chk("reload score", 64'(score), 0);
      chk("reload combo", 64'(combo), 0);
      chk("reload max", 64'(max_combo), 0);
      step(0, 1, 0, 4'hF, M5);
      chk("reload start run", 64'(running), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
